// File: rtl/fir_testvec_gen.sv
// Test-vector source for the FIR input: frames of impulse/step/ramp/square/PRBS samples over AXI-Stream.
// Optional PRBS mode (mode 5) is built only when FIR_TESTVEC_PRBS_EN is defined.
module fir_testvec_gen #(
    parameter int          FRAME_LEN = 64,
    parameter logic [15:0] RAMP_STEP = 16'd256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] testvec_sel,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frame_cnt
);

    localparam int               IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_HALF  = IDX_W'(FRAME_LEN / 2);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [15:0]      ramp_q, ramp_d;
    logic [7:0]       gap_q, gap_d;
    logic [3:0]       mode_q, mode_d;
    logic [7:0]       div_q, div_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      sample;
    logic             transfer;
    logic             sel_mode_ok;
    logic             unused_sel;

    assign unused_sel = ^testvec_sel[7:4];
    assign transfer   = (state_q == VALID) && m_axis_tready;

`ifdef FIR_TESTVEC_PRBS_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Right-shifting Fibonacci form: taps 16,14,13,11 map to bits 0,2,3,5.
    assign lfsr_fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign sel_mode_ok = (testvec_sel[3:0] >= 4'd1) && (testvec_sel[3:0] <= 4'd5);

    always_comb begin
        lfsr_d = lfsr_q;
        if (transfer) begin
            lfsr_d = {lfsr_fb, lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign sel_mode_ok = (testvec_sel[3:0] >= 4'd1) && (testvec_sel[3:0] <= 4'd4);
`endif

    // Sample depends only on registered state, so it holds while the sink stalls.
    always_comb begin
        sample = 16'h0000;
        case (mode_q)
            4'd1:    sample = (index_q == '0) ? 16'h7FFF : 16'h0000;
            4'd2:    sample = (index_q < IDX_HALF) ? 16'h0000 : 16'h4000;
            4'd3:    sample = ramp_q;
            4'd4:    sample = (index_q < IDX_HALF) ? 16'h2000 : 16'hE000;
`ifdef FIR_TESTVEC_PRBS_EN
            4'd5:    sample = lfsr_q;
`endif
            default: sample = 16'h0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        ramp_d      = ramp_q;
        gap_d       = gap_q;
        mode_d      = mode_q;
        div_d       = div_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable && sel_mode_ok) begin
                    mode_d  = testvec_sel[3:0];
                    div_d   = testvec_sel[15:8];
                    index_d = '0;
                    ramp_d  = 16'h0000;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (transfer) begin
                    index_d = index_q + 1'b1;
                    ramp_d  = ramp_q + RAMP_STEP;
                    if (index_q == IDX_LAST) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = IDLE;
                    end else if (div_q != 8'd0) begin
                        gap_d   = div_q;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // Loaded with DIV on entry, so the last gap cycle sees a count of 1.
                if (gap_q <= 8'd1) begin
                    gap_d   = 8'd0;
                    state_d = VALID;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            index_q     <= '0;
            ramp_q      <= 16'h0000;
            gap_q       <= 8'd0;
            mode_q      <= 4'd0;
            div_q       <= 8'd0;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            ramp_q      <= ramp_d;
            gap_q       <= gap_d;
            mode_q      <= mode_d;
            div_q       <= div_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_axis_tvalid = (state_q == VALID);
    assign m_axis_tdata  = (state_q == VALID) ? sample : 16'h0000;
    assign m_axis_tlast  = (state_q == VALID) && (index_q == IDX_LAST);
    assign frame_cnt     = frame_cnt_q;

endmodule
